alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  Reservation station for the integer ALU. Holds dispatched ALU/branch ops until both operands are ready.
//  Snoops the ALU and LSB CDBs for operand tags. Issues one ready op per cycle to the combinational ALU
//  through registered outputs (alu_en, rs_*). Sits between dispatch/decode and the ALU.
// PARAMETERS
//  RS_DEPTH  8   number of entries (power of 2, >=2)
//  RS_IDX_W  3   log2(RS_DEPTH)
// PORTS
//  clk            in   1          clock, rising edge
//  rst_n          in   1          asynchronous active-low reset
//  rdy            in   1          global ready; low = freeze all state
//  rob_flush      in   1          misprediction flush; clears all entries
//  disp_valid     in   1          dispatch request this cycle
//  disp_opt       in   INST_OPT   operation code
//  disp_rdy1      in   1          operand 1 value valid
//  disp_val1      in   WORD       operand 1 value (used if disp_rdy1)
//  disp_q1        in   ROB_IDX    operand 1 producer tag (used if !disp_rdy1)
//  disp_rdy2      in   1          operand 2 value valid
//  disp_val2      in   WORD       operand 2 value
//  disp_q2        in   ROB_IDX    operand 2 producer tag
//  disp_imm       in   WORD       immediate
//  disp_rob_idx   in   ROB_IDX    destination ROB entry
//  rs_full        out  1          no free entry; dispatch must not be asserted
//  cdb_alu_valid/src/val  in 1/ROB_IDX/WORD   ALU broadcast
//  cdb_lsb_valid/src/val  in 1/ROB_IDX/WORD   LSB broadcast
//  alu_en         out  1          issue valid (one-cycle pulse per op)
//  rs_opt/rs_val1/rs_val2/rs_imm/rs_rob_idx  out  issued op fields
// BEHAVIOUR
//  - Reset (rst_n=0, async): all busy=0, count=0, alu_en=0, rs_* = 0, rs_full=0.
//  - Priority per edge: reset > !rdy (hold everything, alu_en forced 0) > rob_flush > normal.
//  - Flush: all busy cleared, count=0, alu_en=0 next cycle; dispatch and issue in the flush cycle are dropped.
//  - Dispatch: accepted when disp_valid && !rs_full; written to lowest-index free entry; count+1.
//    disp_valid while rs_full is a protocol error, ignored (assertion in sim).
//  - Wakeup: each busy entry with !rdyN && qN==cdb_x_src && cdb_x_valid captures cdb_x_val and sets rdyN.
//    Both CDBs checked each cycle; ALU bus wins if both match (cannot occur under unique tags).
//  - Issue select: lowest-index entry with busy && rdy1 && rdy2 using registered flags (a wakeup this cycle
//    is issuable next cycle). Selected entry: fields registered to rs_*, alu_en=1, busy cleared; count-1.
//    No ready entry: alu_en=0, rs_* hold previous values.
//  - Issue latency: dispatch with both operands ready -> alu_en at earliest on the 2nd edge after dispatch.
//  - Simultaneous dispatch + issue: count unchanged; the freed slot is not reused in the same cycle.
//  - rs_full = (count == RS_DEPTH), registered; count width RS_IDX_W+1, never wraps.
// CONFIGURATION
//  ALU_RS_CDB_BYPASS_EN defined: dispatch compares disp_q1/q2 (when !disp_rdyN) against both CDBs in the
//   same cycle and stores the broadcast value as ready, so no wakeup is lost.
//  Undefined: no same-cycle compare; the dispatcher guarantees it never sends a tag being broadcast that cycle
//   (it reads the CDB/ROB itself).
// STRUCTURE
//  Shared utils header: INST_OPT_TP, WORD_TP, ROB_IDX_TP widths, OPT_* codes, TRUE/FALSE, ZERO_WORD.
//  One sub-module: rs_prio_enc (RS_DEPTH-bit vector -> lowest set index + found), instantiated twice
//   (free-slot pick, ready-slot pick).
// TESTING
//  1 reset mid-run: fill 3 entries, pulse rst_n low -> alu_en=0, rs_full=0, no issue after release.
//  2 ready dispatch: ADD val1=5 val2=7 rob=3 -> alu_en=1 two edges later, rs_val1=5 rs_val2=7 rs_rob_idx=3.
//  3 wakeup: ADDI q1=6 pending; cdb_lsb_valid src=6 val=0x10 -> issue next cycle with rs_val1=0x10.
//  4 full: dispatch 8 non-ready ops -> rs_full=1; wake entry 2 -> it issues, rs_full=0 following cycle.
//  5 flush: 4 waiting ops, rob_flush=1 -> no alu_en afterwards; CDB match on old tags causes nothing.
//  6 stall: rdy=0 for 3 cycles with ready entry -> alu_en=0 throughout, issues right after rdy=1.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types, widths and opcodes for the integer ALU reservation station.
// Entry layout lives here so the top and the bench agree on field widths.
package alu_rs_pkg;

  localparam int INST_OPT_W = 6;
  localparam int WORD_W     = 32;
  localparam int ROB_IDX_W  = 4;

  typedef logic [INST_OPT_W-1:0] inst_opt_t;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [ROB_IDX_W-1:0]  rob_idx_t;

  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;
  localparam word_t ZERO_WORD = '0;

  localparam inst_opt_t OPT_ADD  = 6'd1;
  localparam inst_opt_t OPT_SUB  = 6'd2;
  localparam inst_opt_t OPT_ADDI = 6'd3;
  localparam inst_opt_t OPT_BEQ  = 6'd4;
  localparam inst_opt_t OPT_AND  = 6'd5;

  typedef struct packed {
    inst_opt_t opt;
    logic      rdy1;
    word_t     val1;
    rob_idx_t  q1;
    logic      rdy2;
    word_t     val2;
    rob_idx_t  q2;
    word_t     imm;
    rob_idx_t  rob_idx;
  } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit priority encoder used for the free-slot and ready-slot picks.
module rs_prio_enc #(
  parameter int RS_DEPTH = 8,
  parameter int RS_IDX_W = 3
) (
  input  logic [RS_DEPTH-1:0] vec,
  output logic [RS_IDX_W-1:0] idx,
  output logic                found
);

  // Scan high-to-low so the last hit written is the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = RS_IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds ops until operands arrive via the CDBs, issues one per cycle.
// Optional ALU_RS_CDB_BYPASS_EN: dispatch also captures a CDB broadcast of its own pending tags.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int RS_IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  rob_flush,
  input  logic                  disp_valid,
  input  logic [INST_OPT_W-1:0] disp_opt,
  input  logic                  disp_rdy1,
  input  logic [WORD_W-1:0]     disp_val1,
  input  logic [ROB_IDX_W-1:0]  disp_q1,
  input  logic                  disp_rdy2,
  input  logic [WORD_W-1:0]     disp_val2,
  input  logic [ROB_IDX_W-1:0]  disp_q2,
  input  logic [WORD_W-1:0]     disp_imm,
  input  logic [ROB_IDX_W-1:0]  disp_rob_idx,
  output logic                  rs_full,
  input  logic                  cdb_alu_valid,
  input  logic [ROB_IDX_W-1:0]  cdb_alu_src,
  input  logic [WORD_W-1:0]     cdb_alu_val,
  input  logic                  cdb_lsb_valid,
  input  logic [ROB_IDX_W-1:0]  cdb_lsb_src,
  input  logic [WORD_W-1:0]     cdb_lsb_val,
  output logic                  alu_en,
  output logic [INST_OPT_W-1:0] rs_opt,
  output logic [WORD_W-1:0]     rs_val1,
  output logic [WORD_W-1:0]     rs_val2,
  output logic [WORD_W-1:0]     rs_imm,
  output logic [ROB_IDX_W-1:0]  rs_rob_idx
);

  localparam logic [RS_IDX_W:0] CNT_ONE  = (RS_IDX_W+1)'(1);
  localparam logic [RS_IDX_W:0] CNT_FULL = (RS_IDX_W+1)'(RS_DEPTH);

  rs_entry_t entry_q [RS_DEPTH];
  rs_entry_t entry_d [RS_DEPTH];
  rs_entry_t new_entry;

  logic [RS_DEPTH-1:0] busy_q, busy_d, ready_vec;
  logic [RS_IDX_W:0]   count_q, count_d;
  logic                full_q, full_d, alu_en_q, alu_en_d;
  inst_opt_t           rs_opt_q, rs_opt_d;
  word_t               rs_val1_q, rs_val1_d, rs_val2_q, rs_val2_d, rs_imm_q, rs_imm_d;
  rob_idx_t            rs_rob_idx_q, rs_rob_idx_d;
  logic [RS_IDX_W-1:0] free_idx, sel_idx;
  logic                free_found, sel_found, accept, issue;

  // ALU bus is checked first so it wins on a (tag-collision) double match.
  function automatic rs_entry_t wake(input rs_entry_t e);
    rs_entry_t r;
    r = e;
    if (!e.rdy1 && cdb_alu_valid && cdb_alu_src == e.q1) begin
      r.rdy1 = TRUE; r.val1 = cdb_alu_val;
    end else if (!e.rdy1 && cdb_lsb_valid && cdb_lsb_src == e.q1) begin
      r.rdy1 = TRUE; r.val1 = cdb_lsb_val;
    end
    if (!e.rdy2 && cdb_alu_valid && cdb_alu_src == e.q2) begin
      r.rdy2 = TRUE; r.val2 = cdb_alu_val;
    end else if (!e.rdy2 && cdb_lsb_valid && cdb_lsb_src == e.q2) begin
      r.rdy2 = TRUE; r.val2 = cdb_lsb_val;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = busy_q[i] & entry_q[i].rdy1 & entry_q[i].rdy2;
    end
  end

  rs_prio_enc #(.RS_DEPTH(RS_DEPTH), .RS_IDX_W(RS_IDX_W)) u_free_pick (
    .vec(~busy_q), .idx(free_idx), .found(free_found)
  );
  rs_prio_enc #(.RS_DEPTH(RS_DEPTH), .RS_IDX_W(RS_IDX_W)) u_ready_pick (
    .vec(ready_vec), .idx(sel_idx), .found(sel_found)
  );

  assign accept = rdy && !rob_flush && disp_valid && !full_q && free_found;
  assign issue  = rdy && !rob_flush && sel_found;

  always_comb begin
    new_entry = '{opt: disp_opt, rdy1: disp_rdy1, val1: disp_val1, q1: disp_q1,
                  rdy2: disp_rdy2, val2: disp_val2, q2: disp_q2,
                  imm: disp_imm, rob_idx: disp_rob_idx};
`ifdef ALU_RS_CDB_BYPASS_EN
    new_entry = wake(new_entry);
`endif
  end

  always_comb begin
    entry_d      = entry_q;
    busy_d       = busy_q;
    count_d      = count_q;
    alu_en_d     = FALSE;
    rs_opt_d     = rs_opt_q;
    rs_val1_d    = rs_val1_q;
    rs_val2_d    = rs_val2_q;
    rs_imm_d     = rs_imm_q;
    rs_rob_idx_d = rs_rob_idx_q;
    if (rdy && rob_flush) begin
      busy_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i]) entry_d[i] = wake(entry_q[i]);
      end
      if (issue) begin
        rs_opt_d        = entry_q[sel_idx].opt;
        rs_val1_d       = entry_q[sel_idx].val1;
        rs_val2_d       = entry_q[sel_idx].val2;
        rs_imm_d        = entry_q[sel_idx].imm;
        rs_rob_idx_d    = entry_q[sel_idx].rob_idx;
        alu_en_d        = TRUE;
        busy_d[sel_idx] = FALSE;
      end
      // free_idx comes from busy_q, so a slot freed by this issue is never the target.
      if (accept) begin
        entry_d[free_idx] = new_entry;
        busy_d[free_idx]  = TRUE;
      end
      if (accept && !issue)      count_d = count_q + CNT_ONE;
      else if (!accept && issue) count_d = count_q - CNT_ONE;
    end
    full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) entry_q[i] <= '0;
      busy_q       <= '0;
      count_q      <= '0;
      full_q       <= FALSE;
      alu_en_q     <= FALSE;
      rs_opt_q     <= '0;
      rs_val1_q    <= ZERO_WORD;
      rs_val2_q    <= ZERO_WORD;
      rs_imm_q     <= ZERO_WORD;
      rs_rob_idx_q <= '0;
    end else begin
      entry_q      <= entry_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
      full_q       <= full_d;
      alu_en_q     <= alu_en_d;
      rs_opt_q     <= rs_opt_d;
      rs_val1_q    <= rs_val1_d;
      rs_val2_q    <= rs_val2_d;
      rs_imm_q     <= rs_imm_d;
      rs_rob_idx_q <= rs_rob_idx_d;
    end
  end

  assign rs_full    = full_q;
  assign alu_en     = alu_en_q;
  assign rs_opt     = rs_opt_q;
  assign rs_val1    = rs_val1_q;
  assign rs_val2    = rs_val2_q;
  assign rs_imm     = rs_imm_q;
  assign rs_rob_idx = rs_rob_idx_q;

  // Dispatching into a full station is a dispatcher bug; the op is silently dropped.
  assert property (@(posedge clk) disable iff (!rst_n) !(rdy && disp_valid && rs_full));

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, ready issue, CDB wakeup, full, flush and stall scenarios.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk, rst_n, rdy, rob_flush;
  logic disp_valid, disp_rdy1, disp_rdy2;
  logic [INST_OPT_W-1:0] disp_opt;
  logic [WORD_W-1:0] disp_val1, disp_val2, disp_imm;
  logic [ROB_IDX_W-1:0] disp_q1, disp_q2, disp_rob_idx;
  logic rs_full, alu_en;
  logic cdb_alu_valid, cdb_lsb_valid;
  logic [ROB_IDX_W-1:0] cdb_alu_src, cdb_lsb_src;
  logic [WORD_W-1:0] cdb_alu_val, cdb_lsb_val;
  logic [INST_OPT_W-1:0] rs_opt;
  logic [WORD_W-1:0] rs_val1, rs_val2, rs_imm;
  logic [ROB_IDX_W-1:0] rs_rob_idx;

  int checks = 0;
  int failures = 0;

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rob_flush(rob_flush),
    .disp_valid(disp_valid), .disp_opt(disp_opt),
    .disp_rdy1(disp_rdy1), .disp_val1(disp_val1), .disp_q1(disp_q1),
    .disp_rdy2(disp_rdy2), .disp_val2(disp_val2), .disp_q2(disp_q2),
    .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx), .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_src(cdb_lsb_src), .cdb_lsb_val(cdb_lsb_val),
    .alu_en(alu_en), .rs_opt(rs_opt), .rs_val1(rs_val1), .rs_val2(rs_val2),
    .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [INST_OPT_W-1:0] opt,
                      input logic r1, input logic [31:0] v1, input logic [3:0] q1,
                      input logic r2, input logic [31:0] v2, input logic [3:0] q2,
                      input logic [31:0] imm, input logic [3:0] rob);
    disp_valid = 1'b1; disp_opt = opt;
    disp_rdy1 = r1; disp_val1 = v1; disp_q1 = q1;
    disp_rdy2 = r2; disp_val2 = v2; disp_q2 = q2;
    disp_imm = imm; disp_rob_idx = rob;
    tick();
    disp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rob_flush = 1'b0;
    disp_valid = 1'b0; disp_opt = '0; disp_rdy1 = 1'b0; disp_val1 = '0; disp_q1 = '0;
    disp_rdy2 = 1'b0; disp_val2 = '0; disp_q2 = '0; disp_imm = '0; disp_rob_idx = '0;
    cdb_alu_valid = 1'b0; cdb_alu_src = '0; cdb_alu_val = '0;
    cdb_lsb_valid = 1'b0; cdb_lsb_src = '0; cdb_lsb_val = '0;
    #22 rst_n = 1'b1;
    tick();
    check("reset_alu_en", alu_en, 0);
    check("reset_rs_full", rs_full, 0);
    check("reset_rs_val1", rs_val1, 0);

    // 1: reset mid-run with a pending ready entry
    disp(OPT_ADD, 1, 32'd1, 0, 1, 32'd1, 0, 0, 4'd1);
    disp(OPT_ADD, 1, 32'd2, 0, 1, 32'd2, 0, 0, 4'd2);
    disp(OPT_ADD, 1, 32'd3, 0, 1, 32'd3, 0, 0, 4'd3);
    check("midrun_issue_before_reset", alu_en, 1);
    check("midrun_issue_rob", rs_rob_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_alu_en", alu_en, 0);
    check("async_reset_rs_full", rs_full, 0);
    check("async_reset_rob", rs_rob_idx, 0);
    #2 rst_n = 1'b1;
    tick(); check("post_reset_no_issue_0", alu_en, 0);
    tick(); check("post_reset_no_issue_1", alu_en, 0);
    tick(); check("post_reset_no_issue_2", alu_en, 0);

    // 2: ready dispatch issues on the second edge
    disp(OPT_ADD, 1, 32'd5, 0, 1, 32'd7, 0, 0, 4'd3);
    check("ready_first_edge_idle", alu_en, 0);
    tick();
    check("ready_alu_en", alu_en, 1);
    check("ready_opt", rs_opt, OPT_ADD);
    check("ready_val1", rs_val1, 5);
    check("ready_val2", rs_val2, 7);
    check("ready_rob", rs_rob_idx, 3);
    tick();
    check("ready_pulse_end", alu_en, 0);
    check("ready_val1_hold", rs_val1, 5);

    // 3: wakeup from LSB CDB
    disp(OPT_ADDI, 0, 32'd0, 4'd6, 1, 32'd0, 0, 32'd4, 4'd5);
    tick();
    check("wake_waiting", alu_en, 0);
    cdb_lsb_valid = 1'b1; cdb_lsb_src = 4'd6; cdb_lsb_val = 32'h10;
    tick();
    cdb_lsb_valid = 1'b0;
    check("wake_cycle_no_issue", alu_en, 0);
    tick();
    check("wake_alu_en", alu_en, 1);
    check("wake_val1", rs_val1, 32'h10);
    check("wake_imm", rs_imm, 4);
    check("wake_rob", rs_rob_idx, 5);
    check("wake_opt", rs_opt, OPT_ADDI);

    // 4: fill all 8 entries, then wake entry 2
    for (int i = 0; i < 8; i++) begin
      check("fill_not_full", rs_full, 0);
      disp(OPT_SUB, 0, 32'd0, 4'(8 + i), 1, 32'd1, 0, 0, 4'(i));
    end
    check("full_set", rs_full, 1);
    check("full_no_issue", alu_en, 0);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd10; cdb_alu_val = 32'h22;
    tick();
    cdb_alu_valid = 1'b0;
    check("full_during_wake", rs_full, 1);
    tick();
    check("full_issue_en", alu_en, 1);
    check("full_issue_rob", rs_rob_idx, 2);
    check("full_issue_val1", rs_val1, 32'h22);
    check("full_cleared", rs_full, 0);

    // 5: flush drops waiting ops and a same-cycle dispatch
    rob_flush = 1'b1;
    tick();
    rob_flush = 1'b0;
    check("flush_rs_full", rs_full, 0);
    disp(OPT_AND, 0, 32'd0, 4'd1, 0, 32'd0, 4'd2, 0, 4'd11);
    disp(OPT_AND, 0, 32'd0, 4'd3, 1, 32'd0, 0, 0, 4'd12);
    disp(OPT_AND, 0, 32'd0, 4'd4, 1, 32'd0, 0, 0, 4'd13);
    disp(OPT_AND, 1, 32'd0, 0, 0, 32'd0, 4'd5, 0, 4'd14);
    rob_flush = 1'b1;
    disp(OPT_ADD, 1, 32'd9, 0, 1, 32'd9, 0, 0, 4'd9);
    rob_flush = 1'b0;
    check("flush_alu_en", alu_en, 0);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd1; cdb_alu_val = 32'h33;
    cdb_lsb_valid = 1'b1; cdb_lsb_src = 4'd2; cdb_lsb_val = 32'h44;
    tick();
    cdb_alu_src = 4'd3; cdb_lsb_src = 4'd5;
    tick();
    cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0;
    check("flush_old_tag_0", alu_en, 0);
    tick(); check("flush_old_tag_1", alu_en, 0);
    tick(); check("flush_old_tag_2", alu_en, 0);
    check("flush_rob_hold", rs_rob_idx, 2);

    // 6: stall holds a ready entry, issues right after release
    disp(OPT_SUB, 1, 32'd20, 0, 1, 32'd3, 0, 0, 4'd7);
    rdy = 1'b0;
    tick(); check("stall_0", alu_en, 0);
    tick(); check("stall_1", alu_en, 0);
    tick(); check("stall_2", alu_en, 0);
    rdy = 1'b1;
    tick();
    check("stall_release_en", alu_en, 1);
    check("stall_release_rob", rs_rob_idx, 7);
    check("stall_release_val1", rs_val1, 20);
    check("stall_release_val2", rs_val2, 3);
    tick();
    check("stall_pulse_end", alu_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
